pipe_hazard_ctrl: RTL and testbench

- Central pipeline-control unit for the five-stage Y86-64 core.
- Generates per-stage stall/bubble for the F, D, E, M and W pipeline registers from load-use, ret and branch-mispredict hazards.
- Tracks exception status through an RUN/DRAIN/HALTED state machine, freezing the pipe once a faulting instruction retires.
- Optionally keeps performance counters; replaces the per-stage ad-hoc stall/bubble wiring in the core top level.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the Y86-64 pipeline datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard sources), slave = control unit.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 3,
  parameter int REG_W  = 4
);
  logic [3:0]        D_icode_i;
  logic [REG_W-1:0]  d_srcA_i;
  logic [REG_W-1:0]  d_srcB_i;
  logic [3:0]        E_icode_i;
  logic [REG_W-1:0]  E_dstM_i;
  logic              e_cnd_i;
  logic [3:0]        M_icode_i;
  logic [STAT_W-1:0] m_stat_i;
  logic [STAT_W-1:0] W_stat_i;

  logic              F_stall_o, F_bubble_o;
  logic              D_stall_o, D_bubble_o;
  logic              E_stall_o, E_bubble_o;
  logic              M_stall_o, M_bubble_o;
  logic              W_stall_o, W_bubble_o;
  logic              set_cc_o;
  logic              halted_o;
  logic [STAT_W-1:0] final_stat_o;
  logic [CNT_W-1:0]  cyc_cnt_o, ret_cnt_o, stall_cnt_o, mispred_cnt_o;

  modport master (
    output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_cnd_i,
           M_icode_i, m_stat_i, W_stat_i,
    input  F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, set_cc_o, halted_o,
           final_stat_o, cyc_cnt_o, ret_cnt_o, stall_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_cnd_i,
           M_icode_i, m_stat_i, W_stat_i,
    output F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o,
           M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, set_cc_o, halted_o,
           final_stat_o, cyc_cnt_o, ret_cnt_o, stall_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble and exception-status control for the five-stage Y86-64 pipeline.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 3,
  parameter int REG_W  = 4
) (
  input logic               clk_i,
  input logic               rst_n_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [3:0]        IC_OPQ    = 4'h6;
  localparam logic [3:0]        IC_MRMOVQ = 4'h5;
  localparam logic [3:0]        IC_JXX    = 4'h7;
  localparam logic [3:0]        IC_RET    = 4'h9;
  localparam logic [3:0]        IC_POPQ   = 4'hB;
  localparam logic [STAT_W-1:0] STAT_AOK  = STAT_W'(1);
  localparam logic [REG_W-1:0]  RNONE     = {REG_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t            state_r, next_state_s;
  logic              load_use_s, ret_haz_s, mispred_s;
  logic              f_stall_s, f_bubble_s, d_stall_s, d_bubble_s, e_stall_s, e_bubble_s;
  logic              m_stall_s, m_bubble_s, w_stall_s, w_bubble_s, set_cc_s;
  logic              halted_r;
  logic [STAT_W-1:0] final_stat_r;

  // Hazard detection from the current pipeline-register contents
  always_comb begin
    load_use_s = ((hz.E_icode_i == IC_MRMOVQ) || (hz.E_icode_i == IC_POPQ)) &&
                 (hz.E_dstM_i != RNONE) &&
                 ((hz.E_dstM_i == hz.d_srcA_i) || (hz.E_dstM_i == hz.d_srcB_i));
    ret_haz_s  = (hz.D_icode_i == IC_RET) || (hz.E_icode_i == IC_RET) ||
                 (hz.M_icode_i == IC_RET);
    mispred_s  = (hz.E_icode_i == IC_JXX) && !hz.e_cnd_i;
  end

  // Next-state selection and per-stage stall/bubble decode
  always_comb begin
    next_state_s = state_r;
    f_stall_s    = 1'b0;
    f_bubble_s   = 1'b0;
    d_stall_s    = 1'b0;
    d_bubble_s   = 1'b0;
    e_stall_s    = 1'b0;
    e_bubble_s   = 1'b0;
    m_stall_s    = 1'b0;
    m_bubble_s   = 1'b0;
    w_stall_s    = 1'b0;
    w_bubble_s   = 1'b0;
    case (state_r)
      ST_RUN, ST_DRAIN: begin
        f_stall_s  = load_use_s | ret_haz_s;
        d_stall_s  = load_use_s;
        // A stalled D register must not also be bubbled, so ret yields to load-use
        d_bubble_s = mispred_s | (ret_haz_s & ~load_use_s);
        e_bubble_s = mispred_s | load_use_s;
        m_bubble_s = (state_r == ST_DRAIN);
        if (hz.W_stat_i != STAT_AOK) begin
          next_state_s = ST_HALTED;
        end else if ((state_r == ST_RUN) && (hz.m_stat_i != STAT_AOK)) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_HALTED: begin
        f_stall_s    = 1'b1;
        d_stall_s    = 1'b1;
        e_stall_s    = 1'b1;
        m_stall_s    = 1'b1;
        w_stall_s    = 1'b1;
        next_state_s = ST_HALTED;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  always_comb begin
    set_cc_s = (hz.E_icode_i == IC_OPQ) && (state_r == ST_RUN) &&
               (hz.m_stat_i == STAT_AOK) && (hz.W_stat_i == STAT_AOK);
  end

  // Exception FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky halt flag and status of the instruction that caused the halt
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halted_r     <= 1'b0;
      final_stat_r <= STAT_AOK;
    end else if ((next_state_s == ST_HALTED) && (state_r != ST_HALTED)) begin
      halted_r     <= 1'b1;
      final_stat_r <= hz.W_stat_i;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_r, ret_cnt_r, stall_cnt_r, mispred_cnt_r;

  // Free-running event counters, frozen once the pipe has halted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_cnt_r     <= '0;
      ret_cnt_r     <= '0;
      stall_cnt_r   <= '0;
      mispred_cnt_r <= '0;
    end else if (state_r != ST_HALTED) begin
      cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
      if (hz.W_stat_i == STAT_AOK) begin
        ret_cnt_r <= ret_cnt_r + CNT_W'(1);
      end
      if (f_stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (mispred_s) begin
        mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
      end
    end
  end

  assign hz.cyc_cnt_o     = cyc_cnt_r;
  assign hz.ret_cnt_o     = ret_cnt_r;
  assign hz.stall_cnt_o   = stall_cnt_r;
  assign hz.mispred_cnt_o = mispred_cnt_r;
`else
  assign hz.cyc_cnt_o     = '0;
  assign hz.ret_cnt_o     = '0;
  assign hz.stall_cnt_o   = '0;
  assign hz.mispred_cnt_o = '0;
`endif

  assign hz.F_stall_o    = f_stall_s;
  assign hz.F_bubble_o   = f_bubble_s;
  assign hz.D_stall_o    = d_stall_s;
  assign hz.D_bubble_o   = d_bubble_s;
  assign hz.E_stall_o    = e_stall_s;
  assign hz.E_bubble_o   = e_bubble_s;
  assign hz.M_stall_o    = m_stall_s;
  assign hz.M_bubble_o   = m_bubble_s;
  assign hz.W_stall_o    = w_stall_s;
  assign hz.W_bubble_o   = w_bubble_s;
  assign hz.set_cc_o     = set_cc_s;
  assign hz.halted_o     = halted_r;
  assign hz.final_stat_o = final_stat_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (counters built 4 bits wide to exercise wrap).
module tb_pipe_hazard_ctrl;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 3;
  localparam int REG_W  = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector order: F_s F_b D_s D_b E_s E_b M_s M_b W_s W_b
  localparam logic [9:0] CTL_IDLE  = 10'b00_00_00_00_00;
  localparam logic [9:0] CTL_LU    = 10'b10_10_01_00_00;
  localparam logic [9:0] CTL_RET   = 10'b10_01_00_00_00;
  localparam logic [9:0] CTL_MISP  = 10'b00_01_01_00_00;
  localparam logic [9:0] CTL_DRAIN = 10'b00_00_00_01_00;
  localparam logic [9:0] CTL_HALT  = 10'b10_10_10_10_10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .STAT_W(STAT_W), .REG_W(REG_W)) hz ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W), .REG_W(REG_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .hz      (hz)
  );

  wire [9:0] ctl = {hz.F_stall_o, hz.F_bubble_o, hz.D_stall_o, hz.D_bubble_o,
                    hz.E_stall_o, hz.E_bubble_o, hz.M_stall_o, hz.M_bubble_o,
                    hz.W_stall_o, hz.W_bubble_o};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int v);
    return PERF ? 32'(v % 16) : 32'd0;
  endfunction

  task automatic idle();
    hz.D_icode_i = 4'h1;
    hz.d_srcA_i  = 4'hF;
    hz.d_srcB_i  = 4'hF;
    hz.E_icode_i = 4'h1;
    hz.E_dstM_i  = 4'hF;
    hz.e_cnd_i   = 1'b0;
    hz.M_icode_i = 4'h1;
    hz.m_stat_i  = 3'd1;
    hz.W_stat_i  = 3'd1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check_eq({tag, "_halted"}, 32'(hz.halted_o), 32'd0);
    check_eq({tag, "_final"}, 32'(hz.final_stat_o), 32'd1);
    check_eq({tag, "_ctl"}, 32'(ctl), 32'(CTL_IDLE));
    check_eq({tag, "_cyc"}, 32'(hz.cyc_cnt_o), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    #12;
    check_eq("rst_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("rst_halted", 32'(hz.halted_o), 32'd0);
    check_eq("rst_final", 32'(hz.final_stat_o), 32'd1);
    check_eq("rst_cnts", 32'({hz.cyc_cnt_o, hz.ret_cnt_o, hz.stall_cnt_o, hz.mispred_cnt_o}), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Load-use on srcA, RNONE destination, then srcB via popq
    next_cycle();
    hz.E_icode_i = 4'h5; hz.E_dstM_i = 4'h3; hz.d_srcA_i = 4'h3;
    @(negedge clk);
    check_eq("lu_srcA", 32'(ctl), 32'(CTL_LU));
    check_eq("lu_setcc", 32'(hz.set_cc_o), 32'd0);
    next_cycle();
    hz.E_dstM_i = 4'hF; hz.d_srcA_i = 4'hF;
    @(negedge clk);
    check_eq("lu_rnone", 32'(ctl), 32'(CTL_IDLE));
    next_cycle();
    idle(); hz.E_icode_i = 4'hB; hz.E_dstM_i = 4'h3; hz.d_srcB_i = 4'h3;
    @(negedge clk);
    check_eq("lu_srcB_popq", 32'(ctl), 32'(CTL_LU));

    // Ret in D for three cycles, then in E, then in M
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      idle();
      if (i < 3)       hz.D_icode_i = 4'h9;
      else if (i == 3) hz.E_icode_i = 4'h9;
      else             hz.M_icode_i = 4'h9;
      @(negedge clk);
      check_eq($sformatf("ret_%0d", i), 32'(ctl), 32'(CTL_RET));
    end
    next_cycle();
    idle(); hz.D_icode_i = 4'h9; hz.E_icode_i = 4'h5; hz.E_dstM_i = 4'h2; hz.d_srcA_i = 4'h2;
    @(negedge clk);
    check_eq("ret_plus_lu", 32'(ctl), 32'(CTL_LU));

    // Mispredict, taken branch, stall counting, set_cc
    do_reset("rst_b");
    next_cycle();
    hz.E_icode_i = 4'h7; hz.e_cnd_i = 1'b0;
    @(negedge clk);
    check_eq("misp_ctl", 32'(ctl), 32'(CTL_MISP));
    next_cycle();
    hz.e_cnd_i = 1'b1;
    @(negedge clk);
    check_eq("taken_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("misp_cnt1", 32'(hz.mispred_cnt_o), pc(1));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle(); hz.E_icode_i = 4'h5; hz.E_dstM_i = 4'h4; hz.d_srcB_i = 4'h4;
    end
    next_cycle();
    idle(); hz.E_icode_i = 4'h6;
    @(negedge clk);
    check_eq("misp_cnt_hold", 32'(hz.mispred_cnt_o), pc(1));
    check_eq("stall_cnt3", 32'(hz.stall_cnt_o), pc(3));
    check_eq("setcc_run", 32'(hz.set_cc_o), 32'd1);
    next_cycle();
    hz.W_stat_i = 3'd2;
    @(negedge clk);
    check_eq("setcc_wbad", 32'(hz.set_cc_o), 32'd0);

    // Exception: m_stat ADR -> DRAIN -> HALTED, then frozen
    do_reset("rst_c");
    next_cycle();
    hz.m_stat_i = 3'd3; hz.E_icode_i = 4'h6;
    @(negedge clk);
    check_eq("exc_n_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("exc_n_setcc", 32'(hz.set_cc_o), 32'd0);
    next_cycle();
    hz.m_stat_i = 3'd1; hz.W_stat_i = 3'd3;
    @(negedge clk);
    check_eq("drain_ctl", 32'(ctl), 32'(CTL_DRAIN));
    check_eq("drain_setcc", 32'(hz.set_cc_o), 32'd0);
    check_eq("drain_halted", 32'(hz.halted_o), 32'd0);
    next_cycle();
    hz.W_stat_i = 3'd1; hz.E_icode_i = 4'h7; hz.e_cnd_i = 1'b0;
    @(negedge clk);
    check_eq("halt_halted", 32'(hz.halted_o), 32'd1);
    check_eq("halt_final", 32'(hz.final_stat_o), 32'd3);
    check_eq("halt_ctl", 32'(ctl), 32'(CTL_HALT));
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("halt_terminal", 32'(ctl), 32'(CTL_HALT));
    check_eq("halt_final_hold", 32'(hz.final_stat_o), 32'd3);
    check_eq("halt_cyc_frozen", 32'(hz.cyc_cnt_o), pc(3));
    check_eq("halt_ret_frozen", 32'(hz.ret_cnt_o), pc(2));
    check_eq("halt_misp_frozen", 32'(hz.mispred_cnt_o), pc(0));

    // Asynchronous reset out of HALTED, then direct RUN->HALTED priority
    do_reset("rst_halt");
    next_cycle();
    hz.m_stat_i = 3'd4; hz.W_stat_i = 3'd4;
    next_cycle();
    idle();
    @(negedge clk);
    check_eq("direct_halted", 32'(hz.halted_o), 32'd1);
    check_eq("direct_final", 32'(hz.final_stat_o), 32'd4);
    check_eq("direct_ctl", 32'(ctl), 32'(CTL_HALT));

    // Asynchronous reset in the middle of DRAIN
    do_reset("rst_d");
    next_cycle();
    hz.m_stat_i = 3'd2;
    next_cycle();
    idle();
    @(negedge clk);
    check_eq("drain2_ctl", 32'(ctl), 32'(CTL_DRAIN));
    do_reset("rst_drain");
    next_cycle();
    @(negedge clk);
    check_eq("resume_ctl", 32'(ctl), 32'(CTL_IDLE));
    check_eq("resume_halted", 32'(hz.halted_o), 32'd0);

    // Counter wrap at 4 bits
    do_reset("rst_w");
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_eq("cyc_15", 32'(hz.cyc_cnt_o), pc(15));
    @(posedge clk);
    @(negedge clk);
    check_eq("cyc_wrap", 32'(hz.cyc_cnt_o), pc(16));
    check_eq("ret_wrap", 32'(hz.ret_cnt_o), pc(16));
    @(posedge clk);
    @(negedge clk);
    check_eq("cyc_17", 32'(hz.cyc_cnt_o), pc(17));
    check_eq("stall_idle", 32'(hz.stall_cnt_o), pc(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
